// File: rtl/dcs_pkg.sv
// rtl/dcs_pkg.sv - shared constants and state types for the DCS result requantiser
package dcs_pkg;

    localparam int N_ELEM = 8;
    localparam int IN_W   = 32;
    localparam int OUT_W  = 8;
    localparam int SH_W   = 5;
    localparam int CNT_W  = $clog2(N_ELEM);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        EMIT
    } emit_state_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_st_t;

endpackage

// File: rtl/dcs_requant_if.sv
// rtl/dcs_requant_if.sv - input beat stream and requantised output stream bundle
interface dcs_requant_if;
    import dcs_pkg::*;

    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic [SH_W-1:0]  out_shift;
    logic             ovf_err;

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, out_shift, ovf_err
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, out_shift, ovf_err
    );

endinterface

// File: rtl/dcs_shift_calc.sv
// rtl/dcs_shift_calc.sv - leading-one detect turning a vector max into the right-shift that fits OUT_W bits
module dcs_shift_calc
    import dcs_pkg::*;
(
    input  logic [IN_W-1:0] max_val,
    output logic [SH_W-1:0] shift
);

    // Ascending scan: the highest set bit at or above OUT_W wins; lower bits need no shift.
    always_comb begin
        shift = '0;
        for (int i = OUT_W; i < IN_W; i++) begin
            if (max_val[i]) begin
                shift = SH_W'(i + 1 - OUT_W);
            end
        end
    end

endmodule

// File: rtl/dcs_requant.sv
// rtl/dcs_requant.sv - ping-pong vector collector with per-vector shift, rounding and saturation to OUT_W
module dcs_requant
    import dcs_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    dcs_requant_if.slave bus
);

    logic [CNT_W-1:0] cnt;
    logic             wr_bank_q;
    logic             drop_q;
    logic             ovf_q;
    bank_st_t         bank_st [2];
    logic [IN_W-1:0]  mem     [2][N_ELEM];
    logic [IN_W-1:0]  bmax    [2];

    logic beat0, last_beat, wr_bank, drop, wr_en, fill_done;

    assign beat0     = bus.in_valid && (cnt == '0);
    assign last_beat = bus.in_valid && (cnt == CNT_W'(N_ELEM - 1));
    assign wr_bank   = beat0 ? (bank_st[0] != EMPTY) : wr_bank_q;
    assign drop      = beat0 ? ((bank_st[0] != EMPTY) && (bank_st[1] != EMPTY)) : drop_q;
    assign wr_en     = bus.in_valid && !drop;
    assign fill_done = wr_en && last_beat;

    emit_state_t      state, state_nxt;
    logic             cur;
    logic [CNT_W-1:0] idx;
    logic [SH_W-1:0]  shift_q;
    logic [SH_W-1:0]  calc_shift;
    logic             take, take_bank, free_en;

    // Counter advances even for dropped vectors so the next beat 0 stays aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            wr_bank_q <= 1'b0;
            drop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (bus.in_valid) begin
            cnt <= cnt + 1'b1;
            if (beat0) begin
                wr_bank_q <= wr_bank;
                drop_q    <= drop;
                if (drop) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][cnt] <= bus.in_data;
            if (beat0 || (bus.in_data > bmax[wr_bank])) begin
                bmax[wr_bank] <= bus.in_data;
            end
        end
    end

    // Fill and free never target the same bank, so each bank updates independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (free_en && (cur == 1'(b))) begin
                    bank_st[b] <= EMPTY;
                end else if (wr_en && (wr_bank == 1'(b))) begin
                    bank_st[b] <= last_beat ? FULL : FILLING;
                end
            end
        end
    end

    dcs_shift_calc u_shift_calc (
        .max_val (bmax[cur]),
        .shift   (calc_shift)
    );

    // A bank completing its fill this cycle is taken at once to reach out_valid two cycles after the last beat.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        take_bank = cur;
        free_en   = 1'b0;
        case (state)
            IDLE: begin
                if (bank_st[0] == FULL) begin
                    take      = 1'b1;
                    take_bank = 1'b0;
                end else if (bank_st[1] == FULL) begin
                    take      = 1'b1;
                    take_bank = 1'b1;
                end else if (fill_done) begin
                    take      = 1'b1;
                    take_bank = wr_bank;
                end
                if (take) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: state_nxt = EMIT;
            EMIT: begin
                if (bus.out_ready && (idx == CNT_W'(N_ELEM - 1))) begin
                    free_en = 1'b1;
                    if ((bank_st[~cur] == FULL) || (fill_done && (wr_bank == ~cur))) begin
                        take      = 1'b1;
                        take_bank = ~cur;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= 1'b0;
            idx     <= '0;
            shift_q <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                cur <= take_bank;
            end
            if (state == SHIFT) begin
                shift_q <= calc_shift;
                idx     <= '0;
            end else if ((state == EMIT) && bus.out_ready) begin
                idx <= idx + 1'b1;
            end
        end
    end

    logic [IN_W-1:0]  word;
    logic [IN_W:0]    rnd, sum, shifted;
    logic [OUT_W-1:0] quant;

    assign word = mem[cur][idx];

    // One extra bit on the rounding add keeps an all-ones word from wrapping before saturation.
    always_comb begin
        rnd = '0;
        if (shift_q != '0) begin
            rnd = (IN_W + 1)'(1) << (shift_q - 1'b1);
        end
        sum     = {1'b0, word} + rnd;
        shifted = sum >> shift_q;
        quant   = (shifted > (IN_W + 1)'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    end

    assign bus.out_valid = (state == EMIT);
    assign bus.out_data  = (state == EMIT) ? quant : '0;
    assign bus.out_last  = (state == EMIT) && (idx == CNT_W'(N_ELEM - 1));
    assign bus.out_shift = shift_q;
    assign bus.ovf_err   = ovf_q;

endmodule
